// File: rtl/inst_encoder.sv
// Purpose: packs RV32 instruction fields into a 32-bit word and writes it to instruction memory at an auto-incrementing pointer.
// Latency: accept at edge N, mem_we (or enc_err) high for one cycle after edge N+2; one word per 3 cycles at best.
// Backpressure: in_ready is high only in IDLE; a field set is taken when in_valid && in_ready at a rising edge.
module inst_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    input  logic        addr_load,
    input  logic [31:0] load_addr,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        enc_err,
    output logic [7:0]  err_cnt,
    output logic [15:0] words_written
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        WRITE  = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    localparam logic [2:0] FMT_R = 3'd5;

    state_t      state;
    logic [2:0]  f_fmt;
    logic [6:0]  f_opcode;
    logic [4:0]  f_rd;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [2:0]  f_funct3;
    logic [6:0]  f_funct7;
    logic [31:0] f_imm;
    logic [31:0] word_q;
    logic [31:0] ptr;

    logic [31:0] enc_word;
    logic        imm_ok;
    logic        enc_legal;
    logic        fits12;
    logic        fits13;
    logic        fits21;

    // Readiness is a pure decode of the state so it is high straight out of reset.
    assign in_ready = (state == IDLE);

    // Signed range checks: a value fits in N signed bits when all bits above bit N-2 agree.
    assign fits12 = (&f_imm[31:11]) | ~(|f_imm[31:11]);
    assign fits13 = (&f_imm[31:12]) | ~(|f_imm[31:12]);
    assign fits21 = (&f_imm[31:20]) | ~(|f_imm[31:20]);

    // Word assembly and legality check from the registered field set.
    always_comb begin
        enc_word = 32'd0;
        imm_ok   = 1'b0;
        case (f_fmt)
            FMT_I: begin
                enc_word = {f_imm[11:0], f_rs1, f_funct3, f_rd, f_opcode};
                imm_ok   = fits12;
            end
            FMT_S: begin
                enc_word = {f_imm[11:5], f_rs2, f_rs1, f_funct3, f_imm[4:0], f_opcode};
                imm_ok   = fits12;
            end
            FMT_B: begin
                enc_word = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, f_funct3,
                            f_imm[4:1], f_imm[11], f_opcode};
                imm_ok   = fits13 & ~f_imm[0];
            end
            FMT_U: begin
                enc_word = {f_imm[31:12], f_rd, f_opcode};
                imm_ok   = ~(|f_imm[11:0]);
            end
            FMT_J: begin
                enc_word = {f_imm[20], f_imm[10:1], f_imm[11], f_imm[19:12], f_rd, f_opcode};
                imm_ok   = fits21 & ~f_imm[0];
            end
            FMT_R: begin
                enc_word = {f_funct7, f_rs2, f_rs1, f_funct3, f_rd, f_opcode};
                imm_ok   = 1'b1;
            end
            default: begin
                enc_word = 32'd0;
                imm_ok   = 1'b0;
            end
        endcase
    end

    assign enc_legal = imm_ok & (f_opcode[1:0] == 2'b11);

    // Control FSM with registered memory/error outputs; strobes default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            f_fmt         <= 3'd0;
            f_opcode      <= 7'd0;
            f_rd          <= 5'd0;
            f_rs1         <= 5'd0;
            f_rs2         <= 5'd0;
            f_funct3      <= 3'd0;
            f_funct7      <= 7'd0;
            f_imm         <= 32'd0;
            word_q        <= 32'd0;
            ptr           <= 32'd0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'd0;
            mem_wdata     <= 32'd0;
            enc_err       <= 1'b0;
            err_cnt       <= 8'd0;
            words_written <= 16'd0;
        end else begin
            mem_we  <= 1'b0;
            enc_err <= 1'b0;
            case (state)
                IDLE: begin
                    // A pointer load on the accept edge takes effect for that instruction.
                    if (addr_load) begin
                        ptr <= load_addr;
                    end
                    if (in_valid) begin
                        f_fmt    <= fmt;
                        f_opcode <= opcode;
                        f_rd     <= rd;
                        f_rs1    <= rs1;
                        f_rs2    <= rs2;
                        f_funct3 <= funct3;
                        f_funct7 <= funct7;
                        f_imm    <= imm;
                        state    <= ENCODE;
                    end
                end
                ENCODE: begin
                    word_q <= enc_word;
                    state  <= enc_legal ? WRITE : ERROR;
                end
                WRITE: begin
                    mem_we        <= 1'b1;
                    mem_addr      <= ptr;
                    mem_wdata     <= word_q;
                    ptr           <= ptr + 32'd4;
                    words_written <= words_written + 16'd1;
                    state         <= IDLE;
                end
                ERROR: begin
                    enc_err <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed table-driven bench for inst_encoder: encodes, range errors, pointer load, reset abort.
// Every transaction is checked at a fixed latency (accept edge + 2) against hand-computed words.
// Inputs are driven and outputs sampled on the falling edge.
module tb_inst_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        addr_load;
    logic [31:0] load_addr;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        enc_err;
    logic [7:0]  err_cnt;
    logic [15:0] words_written;

    inst_encoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .fmt           (fmt),
        .opcode        (opcode),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .funct3        (funct3),
        .funct7        (funct7),
        .imm           (imm),
        .addr_load     (addr_load),
        .load_addr     (load_addr),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .enc_err       (enc_err),
        .err_cnt       (err_cnt),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        err;
        logic [31:0] word;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int          n_cmp;
    int          n_bad;
    logic [31:0] m_ptr;
    logic [15:0] m_words;
    logic [7:0]  m_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 32'd0;
        m_words = 16'd0;
        m_err   = 8'd0;
    endtask

    task automatic drive(input vec_t v);
        fmt    = v.fmt;
        opcode = v.op;
        rd     = v.rd;
        rs1    = v.rs1;
        rs2    = v.rs2;
        funct3 = v.f3;
        funct7 = v.f7;
        imm    = v.imm;
    endtask

    // Called on a falling edge; presents one field set and checks its outcome at fixed latency.
    task automatic run(input vec_t v, input logic ld, input logic [31:0] la, input string nm);
        logic [31:0] prev_addr;
        logic [31:0] prev_data;
        drive(v);
        in_valid  = 1'b1;
        addr_load = ld;
        load_addr = la;
        check({nm, " in_ready"}, 32'(in_ready), 32'd1);
        if (ld) m_ptr = la;
        prev_addr = mem_addr;
        prev_data = mem_wdata;
        @(negedge clk);
        in_valid  = 1'b0;
        addr_load = 1'b0;
        check({nm, " early1"}, 32'({mem_we, enc_err, in_ready}), 32'd0);
        @(negedge clk);
        check({nm, " early2"}, 32'({mem_we, enc_err, in_ready}), 32'd0);
        @(negedge clk);
        if (v.err) begin
            m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
            check({nm, " enc_err"}, 32'(enc_err), 32'd1);
            check({nm, " no_we"}, 32'(mem_we), 32'd0);
            check({nm, " err_cnt"}, 32'(err_cnt), 32'(m_err));
            check({nm, " addr_hold"}, mem_addr, prev_addr);
            check({nm, " data_hold"}, mem_wdata, prev_data);
        end else begin
            m_words = m_words + 16'd1;
            check({nm, " mem_we"}, 32'(mem_we), 32'd1);
            check({nm, " no_err"}, 32'(enc_err), 32'd0);
            check({nm, " addr"}, mem_addr, m_ptr);
            check({nm, " wdata"}, mem_wdata, v.word);
            m_ptr = m_ptr + 32'd4;
        end
        check({nm, " words"}, 32'(words_written), 32'(m_words));
        check({nm, " in_ready_back"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        check({nm, " pulse_end"}, 32'({mem_we, enc_err}), 32'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " mem_we"}, 32'(mem_we), 32'd0);
        check({nm, " mem_addr"}, mem_addr, 32'd0);
        check({nm, " mem_wdata"}, mem_wdata, 32'd0);
        check({nm, " enc_err"}, 32'(enc_err), 32'd0);
        check({nm, " err_cnt"}, 32'(err_cnt), 32'd0);
        check({nm, " words"}, 32'(words_written), 32'd0);
        check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t addi5;
        vec_t jal;
        n_cmp = 0;
        n_bad = 0;
        model_reset();

        //            fmt   opcode       rd     rs1    rs2    f3    f7           imm               err   word
        vecs[0]  = '{3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,        32'd5,            1'b0, 32'h00500093}; // addi x1,x0,5
        vecs[1]  = '{3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,        32'hFFFFFFF8,     1'b0, 32'hFE208CE3}; // beq x1,x2,-8
        vecs[2]  = '{3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,        32'd2048,         1'b1, 32'd0};        // I imm too big
        vecs[3]  = '{3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,        32'd7,            1'b1, 32'd0};        // B odd offset
        vecs[4]  = '{3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,        32'd6,            1'b0, 32'h00208363}; // beq +6
        vecs[5]  = '{3'd3, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,        32'h12345000,     1'b0, 32'h123452B7}; // lui x5
        vecs[6]  = '{3'd5, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, 32'hFFFFFFFF,     1'b0, 32'h402081B3}; // sub x3,x1,x2
        vecs[7]  = '{3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0,        32'hFFFFFFFC,     1'b0, 32'hFE20AE23}; // sw x2,-4(x1)
        vecs[8]  = '{3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,        32'hFFFFF800,     1'b0, 32'h80000093}; // addi -2048
        vecs[9]  = '{3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,        32'd0,            1'b1, 32'd0};        // fmt 6
        vecs[10] = '{3'd0, 7'b0010010, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,        32'd1,            1'b1, 32'd0};        // opcode[1:0]
        vecs[11] = '{3'd3, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,        32'h12345001,     1'b1, 32'd0};        // U low bits
        vecs[12] = '{3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,        32'd1048576,      1'b1, 32'd0};        // J too far
        vecs[13] = '{3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,        32'd4096,         1'b1, 32'd0};        // B too far

        addi5 = vecs[0];
        jal   = '{3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h001000EF};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        addr_load = 1'b0;
        load_addr = 32'd0;
        drive(addi5);
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // First accept on the very first rising edge after release.
        for (int i = 0; i < NVEC; i++) begin
            run(vecs[i], 1'b0, 32'd0, $sformatf("vec%0d", i));
        end

        // Error counter saturates at 255.
        for (int i = 0; i < 256; i++) begin
            run(vecs[2], 1'b0, 32'd0, "sat");
        end
        check("sat final", 32'(err_cnt), 32'd255);

        // Reset while ENCODE is in flight discards the instruction.
        drive(addi5);
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rst_mid quiet%0d", i), 32'({mem_we, enc_err}), 32'd0);
        end
        run(addi5, 1'b0, 32'd0, "post_rst");

        // Pointer load on the same edge as a jal, then a second instruction follows on.
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(jal, 1'b1, 32'h00000100, "jal_load");
        run(addi5, 1'b0, 32'd0, "after_load");
        check("after_load addr", mem_addr, 32'h00000104);
        check("after_load words", 32'(words_written), 32'd2);

        // Pointer load while busy is ignored.
        drive(addi5);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        addr_load = 1'b1;
        load_addr = 32'h0000F000;
        @(negedge clk);
        @(negedge clk);
        addr_load = 1'b0;
        check("busy_load addr", mem_addr, 32'h00000108);
        check("busy_load we", 32'(mem_we), 32'd1);
        m_ptr   = 32'h0000010C;
        m_words = 16'd3;
        @(negedge clk);
        run(vecs[1], 1'b0, 32'd0, "busy_load next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
